// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter; define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input buffer
module uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       TXD,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d, load_data;
   logic txd_q, txd_d, avail, last;
`ifdef UART_TX_FIFO_EN
   localparam bit CHAIN = 1'b1;
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0] occ_q, occ_d;
   logic push, pop;
   assign tx_ready  = occ_q != (AW+1)'(FIFO_DEPTH);
   assign avail     = occ_q != '0;
   assign load_data = mem_q[rd_q];
   assign busy      = state_q != IDLE || avail;
   always_comb begin
      push  = tx_valid && tx_ready;
      pop   = avail && (state_q == IDLE || (state_q == STOP && last));
      rd_d  = pop ? rd_q + AW'(1) : rd_q;
      wr_d  = push ? wr_q + AW'(1) : wr_q;
      occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= tx_data;
      if (reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         occ_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         occ_q <= occ_d;
      end
   end
`else
   localparam bit CHAIN = 1'b0;
   assign tx_ready  = state_q == IDLE;
   assign avail     = tx_valid;
   assign load_data = tx_data;
   assign busy      = state_q != IDLE;
`endif
   assign last = cnt_q == CW'(CLKS_PER_BIT - 1);
   assign TXD  = txd_q;
   function automatic logic lvl(input state_t s, input logic [7:0] sh);
      return s == START ? 1'b0 : s == DATA ? sh[0] : 1'b1;
   endfunction
   always_comb begin
      state_d = state_q;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (avail) begin
               state_d = START;
               shift_d = load_data;
            end
         end
         START: state_d = last ? DATA : START;
         DATA: if (last) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP: if (last) begin
            state_d = CHAIN && avail ? START : IDLE;
            shift_d = CHAIN && avail ? load_data : shift_q;
         end
         default: state_d = IDLE;
      endcase
      // the buffered build pops one cycle later, so it drives the line from the next state to keep latency equal
      txd_d = CHAIN ? lvl(state_d, shift_d) : lvl(state_q, shift_q);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-level line model
module tb_uart_tx;
   localparam int CPB = 4;
`ifdef UART_TX_FIFO_EN
   localparam int GAP = 0;
`else
   localparam int GAP = 1;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic tx_ready, TXD, busy;
   int tests = 0;
   int fails = 0;
   bit done, saw_full;
   logic [7:0] exp_q[$];

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .TXD(TXD), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic exp_lvl(input logic [7:0] b, input int k);
      int s;
      s = k / CPB;
      return s == 0 ? 1'b0 : s == 9 ? 1'b1 : b[s-1];
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      int t = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && t < 500) begin
         saw_full = 1'b1;
         @(negedge clk);
         t++;
      end
      chk("handshake_wait", int'(t < 500), 1);
      @(negedge clk);
   endtask

   task automatic run(input bit scr);
      done = 1'b0;
      fork
         begin
            foreach (exp_q[i]) push(exp_q[i]);
            tx_valid = 1'b0;
            while (!done) begin
               if (scr) tx_data = 8'($urandom);
               @(negedge clk);
            end
         end
         begin
            int t = 0;
            int rc = 0;
            bit first = 1'b1;
            @(negedge clk);
            while (TXD !== 1'b0 && t < 300) begin
               @(negedge clk);
               t++;
            end
            chk("start_wait", int'(t < 300), 1);
            if (t < 300) begin
               foreach (exp_q[i]) begin
                  for (int k = 0; k < 10*CPB; k++) begin
                     if (!first) @(negedge clk);
                     first = 1'b0;
                     chk("txd", int'(TXD), int'(exp_lvl(exp_q[i], k)));
                     if (k < 10*CPB-1) chk("busy_frame", int'(busy), 1);
                     rc += int'(tx_ready);
                  end
                  if (i < exp_q.size()-1)
                     for (int g = 0; g < GAP; g++) begin
                        @(negedge clk);
                        chk("gap_txd", int'(TXD), 1);
                     end
               end
               @(negedge clk);
               chk("after_txd", int'(TXD), 1);
               chk("after_busy", int'(busy), 0);
`ifndef UART_TX_FIFO_EN
               chk("ready_pulses", rc, exp_q.size());
`endif
            end
            done = 1'b1;
         end
      join
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_txd", int'(TXD), 1);
      chk("reset_ready", int'(tx_ready), 1);
      chk("reset_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_txd", int'(TXD), 1);
      chk("idle_busy", int'(busy), 0);
      exp_q = '{8'h55};
      run(1'b0);
      exp_q = '{8'h01};
      run(1'b0);
      exp_q = '{8'h80};
      run(1'b0);
      exp_q = '{8'hA5, 8'h3C};
      run(1'b0);
`ifdef UART_TX_FIFO_EN
      saw_full = 1'b0;
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run(1'b0);
      chk("fifo_full_seen", int'(saw_full), 1);
`endif
      tx_data  = 8'hF0;
      tx_valid = 1'b1;
      chk("mid_ready", int'(tx_ready), 1);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("mid_bit3", int'(TXD), 0);
      chk("mid_busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_txd", int'(TXD), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(tx_ready), 1);
      @(negedge clk);
      chk("rst_hold_txd", int'(TXD), 1);
      exp_q = '{8'h0F};
      run(1'b0);
      repeat (4) begin
         exp_q = '{8'($urandom)};
         run(1'b1);
      end
      exp_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
      run(1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
